// File: rtl/wb_arb2_if.sv
// Pipelined Wishbone bundle (32-bit data, byte selects) shared by the
// arbiter's master-facing and slave-facing ports.
interface if_wb #(
  parameter int AWIDTH = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [3:0]        sel;
  logic [AWIDTH-1:0] adr;
  logic [31:0]       dat_m;
  logic [31:0]       dat_s;
  logic              ack;
  logic              stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_m,
    input  dat_s, ack, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m,
    output dat_s, ack, stall
  );
endinterface

// File: rtl/wb_arb2.sv
// Two-master to one-slave pipelined Wishbone arbiter: round-robin grant,
// per-tenure burst limit, and drain of outstanding transfers before handover.
module wb_arb2 #(
  parameter int AWIDTH    = 32,
  parameter int BURST_MAX = 8,
  parameter int OUTW      = 4
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  if_wb.slave   bus0,
  if_wb.slave   bus1,
  if_wb.master  bus_s
);

  localparam int              BW   = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0]   BMAX = BW'(BURST_MAX);
  localparam logic [OUTW-1:0] OMAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_BUS0, S_BUS1, S_DRAIN} state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_last;
  logic [BW-1:0]     r_beats;
  logic [OUTW-1:0]   r_outst;

  logic              w_own_cyc;
  logic              w_oth_cyc;
  logic              w_own_stb;
  logic              w_active;
  logic              w_burst_hit;
  logic              w_limit;
  logic              w_stb;
  logic              w_accept;
  logic              w_ack_cnt;
  logic [OUTW-1:0]   w_outst_nxt;
  logic [AWIDTH-1:0] w_adr;

  assign w_own_cyc   = r_owner ? bus1.cyc : bus0.cyc;
  assign w_oth_cyc   = r_owner ? bus0.cyc : bus1.cyc;
  assign w_own_stb   = r_owner ? bus1.stb : bus0.stb;
  assign w_active    = (r_state == S_BUS0) || (r_state == S_BUS1);
  assign w_burst_hit = (BURST_MAX != 0) && (r_beats == BMAX) && w_oth_cyc;
  assign w_limit     = w_burst_hit || (r_outst == OMAX);
  assign w_stb       = w_active && w_own_stb && !w_limit;
  assign w_accept    = w_stb && !bus_s.stall;
  // An ack with nothing outstanding is still forwarded but never underflows the count.
  assign w_ack_cnt   = bus_s.ack && (r_outst != '0);

  always_comb begin
    w_outst_nxt = r_outst;
    case ({w_accept, w_ack_cnt})
      2'b10:   w_outst_nxt = r_outst + 1'b1;
      2'b01:   w_outst_nxt = r_outst - 1'b1;
      default: w_outst_nxt = r_outst;
    endcase
  end

  assign w_adr       = r_owner ? bus1.adr : bus0.adr;
  assign bus_s.cyc   = w_active ? w_own_cyc : (r_state == S_DRAIN);
  assign bus_s.stb   = w_stb;
  assign bus_s.we    = r_owner ? bus1.we    : bus0.we;
  assign bus_s.sel   = r_owner ? bus1.sel   : bus0.sel;
  assign bus_s.adr   = w_adr;
  assign bus_s.dat_m = r_owner ? bus1.dat_m : bus0.dat_m;

  assign bus0.dat_s  = bus_s.dat_s;
  assign bus1.dat_s  = bus_s.dat_s;
  assign bus0.ack    = bus_s.ack && !r_owner && ((r_state == S_BUS0) || (r_state == S_DRAIN));
  assign bus1.ack    = bus_s.ack &&  r_owner && ((r_state == S_BUS1) || (r_state == S_DRAIN));
  assign bus0.stall  = (r_state != S_BUS0) || bus_s.stall || w_limit;
  assign bus1.stall  = (r_state != S_BUS1) || bus_s.stall || w_limit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_beats <= '0;
      r_outst <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // On contention the master that did not hold the previous tenure wins.
          if (bus0.cyc && (!bus1.cyc || r_last)) begin
            r_state <= S_BUS0;
            r_owner <= 1'b0;
            r_last  <= 1'b0;
            r_beats <= '0;
            r_outst <= '0;
          end else if (bus1.cyc) begin
            r_state <= S_BUS1;
            r_owner <= 1'b1;
            r_last  <= 1'b1;
            r_beats <= '0;
            r_outst <= '0;
          end
        end
        S_BUS0, S_BUS1: begin
          r_outst <= w_outst_nxt;
          if (w_accept && (BURST_MAX != 0) && (r_beats != BMAX)) begin
            r_beats <= r_beats + 1'b1;
          end
          if (!w_own_cyc) begin
            r_state <= S_IDLE;
          end else if (w_burst_hit) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_outst <= w_outst_nxt;
          if ((w_outst_nxt == '0) || !w_own_cyc) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Scoreboard bench for wb_arb2: master drivers push expected read data on
// accept, a monitor pops and compares on every forwarded ack.
module tb_wb_arb2;
  localparam int AW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  if_wb #(.AWIDTH(AW)) bus0 ();
  if_wb #(.AWIDTH(AW)) bus1 ();
  if_wb #(.AWIDTH(AW)) bus_s ();

  wb_arb2 #(.AWIDTH(AW), .BURST_MAX(8), .OUTW(2)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus0   (bus0),
    .bus1   (bus1),
    .bus_s  (bus_s)
  );

  logic        m_cyc [2];
  logic        m_stb [2];
  logic [31:0] m_adr [2];

  assign bus0.cyc = m_cyc[0];
  assign bus0.stb = m_stb[0];
  assign bus0.we = 1'b0;
  assign bus0.sel = 4'hF;
  assign bus0.adr = m_adr[0];
  assign bus0.dat_m = ~m_adr[0];
  assign bus1.cyc = m_cyc[1];
  assign bus1.stb = m_stb[1];
  assign bus1.we = 1'b0;
  assign bus1.sel = 4'hF;
  assign bus1.adr = m_adr[1];
  assign bus1.dat_m = ~m_adr[1];

  logic        s_ack = 1'b0;
  logic        s_stall = 1'b0;
  logic [31:0] s_dat = '0;
  int          s_delay = 1;
  bit          s_hold = 1'b0;
  bit          s_stall_en = 1'b0;

  assign bus_s.ack   = s_ack;
  assign bus_s.stall = s_stall;
  assign bus_s.dat_s = s_dat;

  typedef struct {int due; logic [31:0] adr;} pend_t;
  pend_t       pend_q[$];
  logic [31:0] exp_q[2][$];

  int vectors = 0;
  int miscompares = 0;
  int ack_cnt[2] = '{0, 0};
  int acc_log[$];
  int acc_cyc[$];
  int rise_log[$];
  int gap_log[$];
  bit seen_hi = 1'b0;
  bit prev_cyc = 1'b0;
  int low_run = 0;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Slave: fixed ack latency, optional hold-off of acks, optional alternating stall.
  always @(posedge clk) begin
    pend_t p;
    #1;
    s_ack = 1'b0;
    if (!s_hold && pend_q.size() != 0 && pend_q[0].due <= cycle) begin
      p = pend_q.pop_front();
      s_ack = 1'b1;
      s_dat = rdata(p.adr);
    end
    s_stall = s_stall_en && cycle[0];
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.ack) begin
        ack_cnt[0]++;
        if (exp_q[0].size() == 0) check("ack_route0", bus0.ack, 1'b0);
        else check("rdata0", bus0.dat_s, exp_q[0].pop_front());
      end
      if (bus1.ack) begin
        ack_cnt[1]++;
        if (exp_q[1].size() == 0) check("ack_route1", bus1.ack, 1'b0);
        else check("rdata1", bus1.dat_s, exp_q[1].pop_front());
      end
      if (bus_s.cyc && bus_s.stb && !bus_s.stall) begin
        pend_q.push_back('{cycle + s_delay, bus_s.adr});
        acc_log.push_back(int'(bus_s.adr[28]));
        acc_cyc.push_back(cycle);
      end
      if (bus_s.cyc && !prev_cyc) begin
        rise_log.push_back(cycle);
        if (seen_hi) gap_log.push_back(low_run);
      end
      if (bus_s.cyc) begin
        seen_hi = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_cyc = bus_s.cyc;
    end
  end

  // Pipelined read master: holds cyc, issues cnt strobes, waits for all acks.
  task automatic xfer(input int n, input int cnt, input logic [31:0] base);
    int sent = 0;
    int guard = 0;
    bit acc;
    m_cyc[n] = 1'b1;
    m_stb[n] = 1'b1;
    m_adr[n] = base;
    while (sent < cnt && guard < 400) begin
      @(negedge clk);
      acc = (n == 0) ? !bus0.stall : !bus1.stall;
      if (acc) exp_q[n].push_back(rdata(m_adr[n]));
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        sent++;
        m_adr[n] = base + 32'(4 * sent);
        if (sent == cnt) m_stb[n] = 1'b0;
      end
    end
    check($sformatf("issue_m%0d", n), sent, cnt);
    m_stb[n] = 1'b0;
    guard = 0;
    while (exp_q[n].size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check($sformatf("acks_pending_m%0d", n), exp_q[n].size(), 0);
    m_cyc[n] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, a0, g0, rb, c0, r, n_acc, guard;
    m_cyc = '{1'b0, 1'b0};
    m_stb = '{1'b0, 1'b0};
    m_adr = '{32'h0, 32'h0};

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_cyc", bus_s.cyc, 1'b0);
    check("rst_stb", bus_s.stb, 1'b0);
    check("rst_stall0", bus0.stall, 1'b1);
    check("rst_stall1", bus1.stall, 1'b1);
    check("rst_ack0", bus0.ack, 1'b0);
    check("rst_ack1", bus1.ack, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single master bus1, 4 reads, slave stalls every other cycle
    s_stall_en = 1'b1;
    b0 = ack_cnt[0]; b1 = ack_cnt[1]; rb = rise_log.size();
    @(posedge clk); #1;
    c0 = cycle;
    xfer(1, 4, 32'h1000_2000);
    check("grant_latency", rise_log[rb], c0 + 1);
    check("single_acks1", ack_cnt[1] - b1, 4);
    check("single_acks0", ack_cnt[0] - b0, 0);
    s_stall_en = 1'b0;

    // Round robin, both continuous, 16 reads each
    @(posedge clk); #1;
    a0 = acc_log.size(); g0 = gap_log.size();
    fork
      xfer(0, 16, 32'h0000_1000);
      xfer(1, 16, 32'h1000_3000);
    join
    check("rr_total", acc_log.size() - a0, 32);
    for (int i = 0; i < 32; i++) check($sformatf("rr_owner[%0d]", i), acc_log[a0 + i], (i / 8) % 2);
    check("rr_gaps", gap_log.size() - g0, 4);
    for (int i = 1; i < 4; i++) check($sformatf("rr_gap[%0d]", i), gap_log[g0 + i], 1);

    // Drain with ack latency 3, bus1 waiting
    s_delay = 3;
    @(posedge clk); #1;
    a0 = acc_log.size(); g0 = gap_log.size(); b0 = ack_cnt[0];
    fork
      xfer(0, 8, 32'h0000_4000);
      xfer(1, 2, 32'h1000_5000);
    join
    check("drain_acks0", ack_cnt[0] - b0, 8);
    for (int i = 0; i < 10; i++) check($sformatf("drain_owner[%0d]", i), acc_log[a0 + i], (i < 8) ? 0 : 1);
    check("drain_gaps", gap_log.size() - g0, 2);
    check("drain_gap", gap_log[g0 + 1], 1);

    // Outstanding cap (3 with OUTW=2), slave withholds acks
    s_delay = 1;
    s_hold = 1'b1;
    @(posedge clk); #1;
    a0 = acc_cyc.size();
    fork
      xfer(0, 4, 32'h0000_6000);
      begin
        repeat (6) @(negedge clk);
        check("cap_accepts", acc_cyc.size() - a0, 3);
        check("cap_stb", bus_s.stb, 1'b0);
        check("cap_stall0", bus0.stall, 1'b1);
        r = cycle + 1;
        s_hold = 1'b0;
        guard = 0;
        while (acc_cyc.size() - a0 < 4 && guard < 20) begin
          @(negedge clk);
          guard++;
        end
        check("cap_resume_cycle", acc_cyc[a0 + 3], r + 1);
      end
    join

    // Abort with two outstanding; late acks must reach nobody
    s_delay = 3;
    @(posedge clk); #1;
    b0 = ack_cnt[0]; b1 = ack_cnt[1]; a0 = acc_log.size();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_7000;
    n_acc = 0; guard = 0;
    while (n_acc < 2 && guard < 50) begin
      @(negedge clk);
      if (!bus0.stall) n_acc++;
      @(posedge clk); #1;
      m_adr[0] = 32'h0000_7000 + 32'(4 * n_acc);
      guard++;
    end
    check("abort_accepts", n_acc, 2);
    m_stb[0] = 1'b0; m_cyc[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    xfer(1, 2, 32'h1000_8000);
    check("abort_acks0", ack_cnt[0] - b0, 0);
    check("abort_acks1", ack_cnt[1] - b1, 2);
    check("abort_owner", acc_log[a0 + 2], 1);

    // Reset mid-tenure of bus0, then both request: bus0 must win
    s_delay = 1;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_cyc", bus_s.cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cyc", bus_s.cyc, 1'b0);
    check("midrst_stall0", bus0.stall, 1'b1);
    check("midrst_stall1", bus1.stall, 1'b1);
    pend_q.delete();
    exp_q[0].delete();
    exp_q[1].delete();
    m_cyc[1] = 1'b1;
    a0 = acc_log.size();
    @(negedge clk) rst_n = 1'b1;
    fork
      xfer(0, 1, 32'h0000_9000);
      xfer(1, 1, 32'h1000_9000);
    join
    check("rst_first_owner", acc_log[a0], 0);
    check("rst_second_owner", acc_log[a0 + 1], 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
